alu_sequencer: RTL and testbench

- Operand/control sequencer that drives the 4-bit ALU from a single 4-bit board input and a load strobe.
- It collects four fields serially: A, B, operation select, and shift amounts.
- It then presents them to the ALU, waits a settle interval, and latches the ALU result and flags into registers for display.
- It is the initiator side of the ALU operand interface; the ALU is purely combinational and is the responder.

---
 rtl/alu_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Purpose  : serial operand/control loader for the 4-bit combinational ALU; captures result + flags.
// Latency  : 4 load strobes to fill fields, then SETTLE_CYCLES cycles in EXEC before capture.
// Backpress: none upstream; load strobes arriving in EXEC are dropped, clear aborts from any state.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   load, clear         - field strobe (data_in valid same cycle), synchronous abort (wins over load)
//   data_in[3:0]        - field value for the current load step
//   alu_a/b/op/op_s/
//   alu_shift_r/l       - registered operand/control outputs driving the ALU
//   alu_resultado,
//   alu_cero/negativo/
//   alu_c_out/overflow  - combinational ALU response, sampled on the capture edge
//   result_q, flags_q   - latched result and {overflow, c_out, negativo, cero}
//   busy, done          - in EXEC / in HOLD
//   step[2:0]           - state encoding for LEDs
//   op_count[7:0]       - completed captures, wraps at 256

module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       clear,
  input  logic [3:0] data_in,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  output logic [1:0] alu_op_s,
  output logic [1:0] alu_shift_r,
  output logic [1:0] alu_shift_l,
  input  logic [3:0] alu_resultado,
  input  logic       alu_cero,
  input  logic       alu_negativo,
  input  logic       alu_c_out,
  input  logic       alu_overflow,
  output logic [3:0] result_q,
  output logic [3:0] flags_q,
  output logic       busy,
  output logic       done,
  output logic [2:0] step,
  output logic [7:0] op_count
);

  // Encoding doubles as the LED step value.
  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    LOAD_SH = 3'd3,
    EXEC    = 3'd4,
    HOLD    = 3'd5
  } state_e;

  // Capture happens on the edge where the counter reaches SETTLE_CYCLES-1,
  // giving exactly SETTLE_CYCLES cycles of stable ALU inputs in EXEC.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [1:0] op_q, op_d;
  logic [1:0] op_s_q, op_s_d;
  logic [1:0] shr_q, shr_d;
  logic [1:0] shl_q, shl_d;
  logic [3:0] result_d;
  logic [3:0] flags_d;
  logic [7:0] opcnt_q, opcnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD_A;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      op_s_q   <= '0;
      shr_q    <= '0;
      shl_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      opcnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      op_s_q   <= op_s_d;
      shr_q    <= shr_d;
      shl_q    <= shl_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      opcnt_q  <= opcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    op_s_d   = op_s_q;
    shr_d    = shr_q;
    shl_d    = shl_q;
    result_d = result_q;
    flags_d  = flags_q;
    opcnt_d  = opcnt_q;

    if (clear) begin
      // Abort: ALU driving fields and op_count deliberately survive so the
      // operator can re-run without reloading everything.
      state_d  = LOAD_A;
      cnt_d    = '0;
      result_d = '0;
      flags_d  = '0;
    end else begin
      unique case (state_q)
        LOAD_A: begin
          if (load) begin
            a_d     = data_in;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (load) begin
            b_d     = data_in;
            state_d = LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (load) begin
            op_d    = data_in[1:0];
            op_s_d  = data_in[3:2];
            state_d = LOAD_OP == state_q ? LOAD_SH : state_q;
          end
        end
        LOAD_SH: begin
          if (load) begin
            shr_d   = data_in[1:0];
            shl_d   = data_in[3:2];
            cnt_d   = '0;
            state_d = EXEC;
          end
        end
        EXEC: begin
          // load is ignored here; driving registers stay frozen.
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == SETTLE_LAST) begin
            result_d = alu_resultado;
            flags_d  = {alu_overflow, alu_c_out, alu_negativo, alu_cero};
            opcnt_d  = opcnt_q + 8'd1;
            state_d  = HOLD;
          end
        end
        HOLD: begin
          // A load here is the A field of the next operation; the other
          // fields keep their previous values until reloaded.
          if (load) begin
            a_d     = data_in;
            state_d = LOAD_B;
          end
        end
        default: begin
          state_d = LOAD_A;
        end
      endcase
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign alu_op_s    = op_s_q;
  assign alu_shift_r = shr_q;
  assign alu_shift_l = shl_q;
  assign op_count    = opcnt_q;
  assign step        = state_q;
  assign busy        = (state_q == EXEC);
  assign done        = (state_q == HOLD);

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam int SETTLE = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic       clear;
  logic [3:0] data_in;
  logic [3:0] alu_resultado;
  logic       alu_cero, alu_negativo, alu_c_out, alu_overflow;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op, alu_op_s, alu_shift_r, alu_shift_l;
  logic [3:0] result_q, flags_q;
  logic       busy, done;
  logic [2:0] step;
  logic [7:0] op_count;

  alu_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .clear        (clear),
    .data_in      (data_in),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_op_s     (alu_op_s),
    .alu_shift_r  (alu_shift_r),
    .alu_shift_l  (alu_shift_l),
    .alu_resultado(alu_resultado),
    .alu_cero     (alu_cero),
    .alu_negativo (alu_negativo),
    .alu_c_out    (alu_c_out),
    .alu_overflow (alu_overflow),
    .result_q     (result_q),
    .flags_q      (flags_q),
    .busy         (busy),
    .done         (done),
    .step         (step),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: number of fields loaded (0..3), 4 while settling,
  // 5 while the result is on display.
  int         m_phase;
  int         m_elapsed;
  logic [3:0] m_a, m_b, m_res, m_flg;
  logic [1:0] m_op, m_ops, m_shr, m_shl;
  int         m_cnt;

  function automatic logic [63:0] dut_vec();
    return 64'({step, busy, done, alu_a, alu_b, alu_op, alu_op_s,
                alu_shift_r, alu_shift_l, result_q, flags_q, op_count});
  endfunction

  function automatic logic [63:0] model_vec();
    return 64'({3'(m_phase), (m_phase == 4), (m_phase == 5), m_a, m_b, m_op, m_ops,
                m_shr, m_shl, m_res, m_flg, 8'(m_cnt)});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0;
    m_a = 0; m_b = 0; m_res = 0; m_flg = 0;
    m_op = 0; m_ops = 0; m_shr = 0; m_shl = 0;
    m_cnt = 0;
  endtask

  task automatic model_edge(input logic ld, input logic clr, input logic [3:0] din,
                            input logic [3:0] sres, input logic [3:0] sflg);
    if (clr) begin
      m_phase = 0; m_elapsed = 0; m_res = 0; m_flg = 0;
    end else if (m_phase == 4) begin
      m_elapsed++;
      if (m_elapsed == SETTLE) begin
        m_res = sres; m_flg = sflg;
        m_cnt = (m_cnt + 1) % 256;
        m_phase = 5;
      end
    end else if (ld) begin
      case (m_phase)
        0, 5: begin m_a = din; m_phase = 1; end
        1: begin m_b = din; m_phase = 2; end
        2: begin m_op = din[1:0]; m_ops = din[3:2]; m_phase = 3; end
        default: begin m_shr = din[1:0]; m_shl = din[3:2]; m_phase = 4; m_elapsed = 0; end
      endcase
    end
  endtask

  // Called at a falling edge: drive inputs, clock once, compare at next falling edge.
  task automatic cycle(input logic ld, input logic clr, input logic [3:0] din,
                       input logic [3:0] sres, input logic [3:0] sflg);
    load = ld; clear = clr; data_in = din; alu_resultado = sres;
    {alu_overflow, alu_c_out, alu_negativo, alu_cero} = sflg;
    @(posedge clk);
    model_edge(ld, clr, din, sres, sflg);
    @(negedge clk);
    check("model", dut_vec(), model_vec());
  endtask

  typedef struct {
    logic       ld, clr;
    logic [3:0] din, sres, sflg;
    logic [2:0] step;
    logic       busy, done;
    logic [3:0] a, b;
    logic [7:0] ctl;   // {op, op_s, shift_r, shift_l}
    logic [3:0] res, flg;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ld, input logic clr, input logic [3:0] din,
                     input logic [3:0] sres, input logic [3:0] sflg,
                     input logic [2:0] st, input logic bz, input logic dn,
                     input logic [3:0] a, input logic [3:0] b, input logic [7:0] ctl,
                     input logic [3:0] res, input logic [3:0] flg, input logic [7:0] cnt);
    vec_t v;
    v.ld = ld; v.clr = clr; v.din = din; v.sres = sres; v.sflg = sflg;
    v.step = st; v.busy = bz; v.done = dn; v.a = a; v.b = b; v.ctl = ctl;
    v.res = res; v.flg = flg; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] c0;
    reset = 1'b1; load = 1'b0; clear = 1'b0; data_in = 4'h0;
    alu_resultado = 4'h0; alu_cero = 0; alu_negativo = 0; alu_c_out = 0; alu_overflow = 0;
    model_reset();

    repeat (2) @(negedge clk);
    check("reset_state", dut_vec(), 64'd0);
    reset = 1'b0;

    //   ld clr din  sres sflg  step bz dn  a     b     ctl    res   flg   cnt
    add(1, 0, 4'h3, 4'h0, 4'h0, 3'd1, 0, 0, 4'h3, 4'h0, 8'h00, 4'h0, 4'h0, 8'd0);
    add(1, 0, 4'h5, 4'h0, 4'h0, 3'd2, 0, 0, 4'h3, 4'h5, 8'h00, 4'h0, 4'h0, 8'd0);
    add(1, 0, 4'h0, 4'h0, 4'h0, 3'd3, 0, 0, 4'h3, 4'h5, 8'h00, 4'h0, 4'h0, 8'd0);
    add(1, 0, 4'h0, 4'h0, 4'h0, 3'd4, 1, 0, 4'h3, 4'h5, 8'h00, 4'h0, 4'h0, 8'd0);
    add(0, 0, 4'h0, 4'hF, 4'hF, 3'd4, 1, 0, 4'h3, 4'h5, 8'h00, 4'h0, 4'h0, 8'd0);
    add(1, 0, 4'hF, 4'hF, 4'hF, 3'd4, 1, 0, 4'h3, 4'h5, 8'h00, 4'h0, 4'h0, 8'd0);
    add(1, 0, 4'hF, 4'h8, 4'h2, 3'd5, 0, 1, 4'h3, 4'h5, 8'h00, 4'h8, 4'h2, 8'd1);
    add(0, 0, 4'h0, 4'hF, 4'hF, 3'd5, 0, 1, 4'h3, 4'h5, 8'h00, 4'h8, 4'h2, 8'd1);
    add(1, 0, 4'h7, 4'h0, 4'h0, 3'd1, 0, 0, 4'h7, 4'h5, 8'h00, 4'h8, 4'h2, 8'd1);
    add(1, 1, 4'h9, 4'h0, 4'h0, 3'd0, 0, 0, 4'h7, 4'h5, 8'h00, 4'h0, 4'h0, 8'd1);
    add(1, 0, 4'hC, 4'h0, 4'h0, 3'd1, 0, 0, 4'hC, 4'h5, 8'h00, 4'h0, 4'h0, 8'd1);
    add(1, 0, 4'h3, 4'h0, 4'h0, 3'd2, 0, 0, 4'hC, 4'h3, 8'h00, 4'h0, 4'h0, 8'd1);
    add(1, 0, 4'hB, 4'h0, 4'h0, 3'd3, 0, 0, 4'hC, 4'h3, 8'hE0, 4'h0, 4'h0, 8'd1);
    add(1, 0, 4'h9, 4'h0, 4'h0, 3'd4, 1, 0, 4'hC, 4'h3, 8'hE6, 4'h0, 4'h0, 8'd1);
    add(0, 0, 4'h0, 4'hF, 4'hF, 3'd4, 1, 0, 4'hC, 4'h3, 8'hE6, 4'h0, 4'h0, 8'd1);
    add(0, 0, 4'h0, 4'hF, 4'hF, 3'd4, 1, 0, 4'hC, 4'h3, 8'hE6, 4'h0, 4'h0, 8'd1);
    add(0, 0, 4'h0, 4'h1, 4'h0, 3'd5, 0, 1, 4'hC, 4'h3, 8'hE6, 4'h1, 4'h0, 8'd2);
    add(1, 0, 4'h2, 4'h0, 4'h0, 3'd1, 0, 0, 4'h2, 4'h3, 8'hE6, 4'h1, 4'h0, 8'd2);
    add(1, 0, 4'h4, 4'h0, 4'h0, 3'd2, 0, 0, 4'h2, 4'h4, 8'hE6, 4'h1, 4'h0, 8'd2);
    add(1, 0, 4'h0, 4'h0, 4'h0, 3'd3, 0, 0, 4'h2, 4'h4, 8'h06, 4'h1, 4'h0, 8'd2);
    add(1, 0, 4'h0, 4'h0, 4'h0, 3'd4, 1, 0, 4'h2, 4'h4, 8'h00, 4'h1, 4'h0, 8'd2);
    add(0, 0, 4'h0, 4'hF, 4'hF, 3'd4, 1, 0, 4'h2, 4'h4, 8'h00, 4'h1, 4'h0, 8'd2);
    add(1, 1, 4'hF, 4'hF, 4'hF, 3'd0, 0, 0, 4'h2, 4'h4, 8'h00, 4'h0, 4'h0, 8'd2);

    foreach (tbl[i]) begin
      cycle(tbl[i].ld, tbl[i].clr, tbl[i].din, tbl[i].sres, tbl[i].sflg);
      check($sformatf("tbl%0d", i), dut_vec(),
            64'({tbl[i].step, tbl[i].busy, tbl[i].done, tbl[i].a, tbl[i].b, tbl[i].ctl,
                 tbl[i].res, tbl[i].flg, tbl[i].cnt}));
    end

    // Random traffic against the model; stub ALU outputs change every cycle
    // so a capture on the wrong edge shows up.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 4'($urandom),
            4'($urandom), 4'($urandom));
    end

    // 256 complete operations bring op_count back to where it started.
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
    c0 = op_count;
    for (int n = 0; n < 256; n++) begin
      for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom));
      for (int k = 0; k < SETTLE; k++) cycle(1'b0, 1'b0, 4'h0, 4'($urandom), 4'($urandom));
    end
    check("op_count_wrap", 64'(op_count), 64'(c0));
    check("wrap_done", 64'(done), 64'd1);

    // Asynchronous reset in LOAD_OP clears everything before the next rising edge.
    cycle(1'b1, 1'b0, 4'h9, 4'h0, 4'h0);
    cycle(1'b1, 1'b0, 4'h6, 4'h0, 4'h0);
    check("pre_reset_step", 64'(step), 64'd2);
    load = 1'b0;
    #2 reset = 1'b1;
    #1 check("async_reset", dut_vec(), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cycle(1'b1, 1'b0, 4'hA, 4'h0, 4'h0);
    check("post_reset_a", 64'(alu_a), 64'hA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
